mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 34 +++
 rtl/mem_access_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle for mem_access_ctrl: pipeline request/response channel plus the
// word-wide data memory / IO port. dbg_state mirrors the controller FSM.
interface mem_access_ctrl_if;
    // Request handshake: a request is taken on a rising edge where
    // req_valid && req_ready; resp_valid is a single-cycle completion pulse
    // with no back-pressure, and resp_err/resp_rdata are meaningful only then.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we,
               dbg_state
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we,
               dbg_state
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store unit between the pipeline and a word-wide memory: alignment and IO
// checks, sub-word extraction with extension, and read-modify-write for sub-word stores.
module mem_access_ctrl #(
    parameter int IO_BIT = 7
) (
    input  logic              clock,
    input  logic              clrn,
    mem_access_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, signed_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word_q;

    logic        accept;
    logic        req_err;
    logic [4:0]  lane_sh;
    logic [31:0] lane_mask, merged, shifted, load_val;

    assign accept = bus.req_valid && (state_q == IDLE);

    // Sub-word accesses are not allowed into IO space.
    always_comb begin
        req_err = 1'b0;
        case (bus.req_size)
            2'b00:   req_err = bus.req_addr[IO_BIT];
            2'b01:   req_err = bus.req_addr[0] | bus.req_addr[IO_BIT];
            2'b10:   req_err = |bus.req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
        end else begin
            if (accept) begin
                we_q     <= bus.req_we;
                signed_q <= bus.req_signed;
                err_q    <= req_err;
                size_q   <= bus.req_size;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end
            if (state_q == CAP) word_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)                                  state_d = RESP;
                    else if (bus.req_we && bus.req_size == 2'b10) state_d = WR;
                    else                                          state_d = RD;
                end
            end
            RD:      state_d = CAP;
            CAP:     state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane shift is 0/8/16/24 bits; halfwords only ever land on 0 or 16.
    assign lane_sh   = {addr_q[1:0], 3'b000};
    assign lane_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    assign merged    = (word_q & ~(lane_mask << lane_sh)) | ((wdata_q & lane_mask) << lane_sh);
    assign shifted   = word_q >> lane_sh;

    always_comb begin
        case (size_q)
            2'b00:   load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_val = word_q;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = '0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_we     = 1'b0;
        bus.dbg_state  = state_q;
        case (state_q)
            IDLE: bus.req_ready = 1'b1;
            RD, CAP: bus.mem_addr = {addr_q[31:2], 2'b00};
            WR: begin
                bus.mem_addr  = {addr_q[31:2], 2'b00};
                bus.mem_we    = 1'b1;
                bus.mem_wdata = (size_q == 2'b10) ? wdata_q : merged;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (err_q || we_q) ? 32'h0 : load_val;
            end
            default: ;
        endcase
    end

endmodule
